// File: rtl/wb_port_scheduler.sv
// wb_port_scheduler: per-lane result FIFOs feeding NUM_PORTS register-file write ports
// through a rotating-priority, write-after-write-safe multi-issue scheduler.
module wb_port_scheduler #(
    parameter int NUM_LANES  = 4,
    parameter int NUM_PORTS  = 3,
    parameter int REG_PTR_W  = 5,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_LANES-1:0]           lane_vld,
    input  logic [NUM_LANES*REG_PTR_W-1:0] lane_ptr,
    input  logic [NUM_LANES*DATA_W-1:0]    lane_data,
    output logic [NUM_LANES-1:0]           lane_rdy,
    output logic [NUM_PORTS-1:0]           port_vld,
    output logic [NUM_PORTS*REG_PTR_W-1:0] port_ptr,
    output logic [NUM_PORTS*DATA_W-1:0]    port_data,
    input  logic [NUM_PORTS-1:0]           port_grant,
    output logic                           wb_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;

    logic [REG_PTR_W-1:0] mem_ptr  [NUM_LANES][FIFO_DEPTH];
    logic [DATA_W-1:0]    mem_data [NUM_LANES][FIFO_DEPTH];
    logic [AW:0]          wr_q [NUM_LANES];
    logic [AW:0]          wr_d [NUM_LANES];
    logic [AW:0]          rd_q [NUM_LANES];
    logic [AW:0]          rd_d [NUM_LANES];
    logic [NUM_LANES-1:0] empty, full, push, pop;
    logic [REG_PTR_W-1:0] head_ptr  [NUM_LANES];
    logic [DATA_W-1:0]    head_data [NUM_LANES];
    logic [NUM_PORTS-1:0] port_vld_q, port_vld_d, taken;
    logic [REG_PTR_W-1:0] port_ptr_q  [NUM_PORTS];
    logic [REG_PTR_W-1:0] port_ptr_d  [NUM_PORTS];
    logic [DATA_W-1:0]    port_data_q [NUM_PORTS];
    logic [DATA_W-1:0]    port_data_d [NUM_PORTS];
    logic [LW-1:0]        rr_q, rr_d;
    logic                 ok, got;

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            empty[i]     = wr_q[i] == rd_q[i];
            full[i]      = wr_q[i][AW-1:0] == rd_q[i][AW-1:0] && wr_q[i][AW] != rd_q[i][AW];
            push[i]      = lane_vld[i] && !full[i];
            head_ptr[i]  = mem_ptr[i][rd_q[i][AW-1:0]];
            head_data[i] = mem_data[i][rd_q[i][AW-1:0]];
        end
    end

    // Rotated walk: pass 0 covers lanes rr..N-1, pass 1 covers lanes 0..rr-1.
    always_comb begin
        pop         = '0;
        taken       = '0;
        rr_d        = rr_q;
        port_vld_d  = port_vld_q & ~port_grant;
        port_ptr_d  = port_ptr_q;
        port_data_d = port_data_q;
        ok          = 1'b0;
        got         = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                ok = !empty[l] && ((r == 0) == (l >= int'(rr_q)));
                for (int p = 0; p < NUM_PORTS; p++)
                    if (port_vld_q[p] && !port_grant[p] && port_ptr_q[p] == head_ptr[l]) ok = 1'b0;
                for (int j = 0; j < NUM_LANES; j++)
                    if (pop[j] && head_ptr[j] == head_ptr[l]) ok = 1'b0;
                got = 1'b0;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (ok && !got && (!port_vld_q[p] || port_grant[p]) && !taken[p]) begin
                        got            = 1'b1;
                        taken[p]       = 1'b1;
                        port_vld_d[p]  = 1'b1;
                        port_ptr_d[p]  = head_ptr[l];
                        port_data_d[p] = head_data[l];
                    end
                end
                if (got) begin
                    pop[l] = 1'b1;
                    rr_d   = LW'((l + 1) % NUM_LANES);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            wr_d[i] = wr_q[i] + {{AW{1'b0}}, push[i]};
            rd_d[i] = rd_q[i] + {{AW{1'b0}}, pop[i]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            port_vld_q  <= '0;
            port_ptr_q  <= '{default: '0};
            port_data_q <= '{default: '0};
            rr_q        <= '0;
            wr_q        <= '{default: '0};
            rd_q        <= '{default: '0};
        end else begin
            port_vld_q  <= port_vld_d;
            port_ptr_q  <= port_ptr_d;
            port_data_q <= port_data_d;
            rr_q        <= rr_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (push[i]) begin
                mem_ptr[i][wr_q[i][AW-1:0]]  <= lane_ptr[i*REG_PTR_W +: REG_PTR_W];
                mem_data[i][wr_q[i][AW-1:0]] <= lane_data[i*DATA_W +: DATA_W];
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        assign port_ptr[g*REG_PTR_W +: REG_PTR_W] = port_ptr_q[g];
        assign port_data[g*DATA_W +: DATA_W]      = port_data_q[g];
    end

    assign port_vld = port_vld_q;
    assign lane_rdy = ~full;
    assign wb_busy  = |port_vld_q || !(&empty);
endmodule
